div3_rr_sched: RTL and testbench

Round-robin scheduler that shares one combinational `is_div_3_top` checker among `NREQ` requesters. Each requester presents a `SIZE`-bit operand with a valid/ready handshake. The scheduler grants one requester per cycle, registers the operand and runs it through the shared checker. It returns the verdict with the requester ID on a single valid/ready response port. It is a two-stage pipeline (operand stage, response stage) with full backpressure.

---
 rtl/div3_rr_sched.sv | 153 +++++++++++++++
 tb/tb_div3_rr_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div3_rr_sched.sv
// Round-robin scheduler sharing one divisible-by-3 checker among NREQ requesters,
// with a registered operand stage and a registered response stage.

module is_div_3_top #(
    parameter int SIZE = 64
) (
    input  logic [SIZE-1:0] digit,
    output logic            out
);

    logic [1:0] residue;
    logic [2:0] sum;

    // 2^i mod 3 alternates 1,2,1,2..., so accumulate weighted set bits modulo 3.
    always_comb begin
        residue = 2'd0;
        sum     = 3'd0;
        for (int i = 0; i < SIZE; i++) begin
            if (digit[i]) begin
                sum     = {1'b0, residue} + (((i % 2) == 0) ? 3'd1 : 3'd2);
                residue = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            end
        end
    end

    assign out = (residue == 2'd0);

endmodule

module div3_rr_sched #(
    parameter  int SIZE = 64,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_digit,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic                 rsp_div,
    output logic [IDW-1:0]       rsp_id,
    input  logic                 rsp_ready
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            op_full_q, op_full_d;
    logic [SIZE-1:0] op_digit_q, op_digit_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_div_q, rsp_div_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic            rsp_adv, op_adv, op_free, xfer, found, chk_out;
    logic [NREQ-1:0] valid_rot;
    logic [IDW-1:0]  offset, winner, ptr_next;
    logic [IDW:0]    idx_sum, nxt_sum;

    // Rotate so bit 0 corresponds to ptr; the lowest set bit is the winner.
    always_comb begin
        valid_rot = NREQ'({req_valid, req_valid} >> ptr_q);
        found     = 1'b0;
        offset    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                found  = 1'b1;
                offset = IDW'(k);
            end
        end
        idx_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (idx_sum >= NREQ_W) begin
            idx_sum = idx_sum - NREQ_W;
        end
        winner   = idx_sum[IDW-1:0];
        nxt_sum  = {1'b0, winner} + (IDW+1)'(1);
        ptr_next = (nxt_sum == NREQ_W) ? '0 : nxt_sum[IDW-1:0];
    end

    always_comb begin
        rsp_adv   = !rsp_valid_q || rsp_ready;
        op_adv    = op_full_q && rsp_adv;
        op_free   = !op_full_q || op_adv;
        xfer      = found && op_free && !rst;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = xfer && (winner == IDW'(i));
        end
    end

    is_div_3_top #(.SIZE(SIZE)) u_chk (
        .digit (op_digit_q),
        .out   (chk_out)
    );

    // A grant refills the operand stage in the same edge the old operand moves on.
    always_comb begin
        ptr_d       = ptr_q;
        op_full_d   = op_full_q;
        op_digit_d  = op_digit_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_div_d   = rsp_div_q;
        rsp_id_d    = rsp_id_q;

        if (xfer) begin
            ptr_d     = ptr_next;
            op_full_d = 1'b1;
            op_id_d   = winner;
            for (int i = 0; i < NREQ; i++) begin
                if (winner == IDW'(i)) begin
                    op_digit_d = req_digit[i*SIZE +: SIZE];
                end
            end
        end else if (op_adv) begin
            op_full_d = 1'b0;
        end

        if (op_adv) begin
            rsp_valid_d = 1'b1;
            rsp_div_d   = chk_out;
            rsp_id_d    = op_id_q;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            op_full_q   <= 1'b0;
            op_digit_q  <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_div_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            op_full_q   <= op_full_d;
            op_digit_q  <= op_digit_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_div_q   <= rsp_div_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_div   = rsp_div_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_div3_rr_sched.sv
// Directed and randomized checks of div3_rr_sched: reset, latency, round-robin order,
// backpressure, mid-operation reset, boundary operands and an in-order scoreboard sweep.

module tb_div3_rr_sched;

    localparam int SIZE = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_digit;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_div;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_ready;

    int nChecks = 0;
    int nFail   = 0;

    int          qId[$];
    bit          qDiv[$];
    int          waitCnt[NREQ];
    logic [3:0]  xferMask;
    logic [63:0] d;
    int          ei;
    bit          ed;

    logic [3:0] rrReady[6] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    int         rrId[5]    = '{0, 1, 2, 3, 0};
    bit         rrDiv[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    div3_rr_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_digit (req_digit),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_div   (rsp_div),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rspReady);
        req_valid = valid;
        rsp_ready = rspReady;
        #1;
    endtask

    task automatic setDigit(input int i, input logic [63:0] v);
        req_digit[i*SIZE +: SIZE] = v;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input bit expValid, input int expId, input bit expDiv);
        checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'(expValid));
        if (expValid) begin
            checkOutput({tag, "_id"}, 64'(rsp_id), 64'(expId));
            checkOutput({tag, "_div"}, 64'(rsp_div), 64'(expDiv));
        end
    endtask

    function automatic logic [63:0] randDigit();
        int unsigned sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return 64'd0;
        if (sel == 1) return '1;
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst       = 1'b1;
        req_digit = '0;
        for (int i = 0; i < NREQ; i++) waitCnt[i] = 0;
        setDigit(0, 64'd3);
        setDigit(1, 64'd4);
        setDigit(2, 64'd5);
        setDigit(3, 64'd6);
        applyStimulus(4'hF, 1'b1);

        // Reset held for two edges with every requester valid
        cycle();
        cycle();
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkRsp("rst_rsp", 1'b0, 0, 1'b0);
        checkOutput("rst_div", 64'(rsp_div), 64'd0);
        checkOutput("rst_id", 64'(rsp_id), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("first_grant", 64'(req_ready), 64'h1);

        // Round-robin with all requesters valid
        for (int k = 0; k < 6; k++) begin
            cycle();
            checkOutput("rr_ready", 64'(req_ready), 64'(rrReady[k]));
            if (k >= 1) checkRsp("rr_rsp", 1'b1, rrId[k-1], rrDiv[k-1]);
            else checkOutput("rr_latency", 64'(rsp_valid), 64'd0);
        end
        applyStimulus(4'h0, 1'b1);
        cycle();
        checkRsp("rr_tail", 1'b1, 1, 1'b0);
        cycle();
        checkRsp("rr_idle", 1'b0, 0, 1'b0);

        // Single requester 2 sends 9, 10, 0
        setDigit(2, 64'd9);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_ready", 64'(req_ready), 64'h4);
        cycle();
        checkRsp("single_lat", 1'b0, 0, 1'b0);
        setDigit(2, 64'd10);
        cycle();
        checkRsp("single_9", 1'b1, 2, 1'b1);
        setDigit(2, 64'd0);
        cycle();
        checkRsp("single_10", 1'b1, 2, 1'b0);
        applyStimulus(4'h0, 1'b1);
        cycle();
        checkRsp("single_0", 1'b1, 2, 1'b1);
        cycle();
        checkRsp("single_idle", 1'b0, 0, 1'b0);

        // Backpressure: consumer stalls for five edges with requesters 1 and 3 valid
        setDigit(1, 64'd7);
        setDigit(3, 64'd15);
        applyStimulus(4'b1010, 1'b0);
        checkOutput("bp_ready0", 64'(req_ready), 64'h8);
        cycle();
        setDigit(3, 64'd16);
        checkOutput("bp_ready1", 64'(req_ready), 64'h2);
        checkRsp("bp_lat", 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            checkOutput("bp_stall_ready", 64'(req_ready), 64'd0);
            checkRsp("bp_hold", 1'b1, 3, 1'b1);
        end
        applyStimulus(4'h0, 1'b1);
        cycle();
        checkRsp("bp_second", 1'b1, 1, 1'b0);
        cycle();
        checkRsp("bp_idle", 1'b0, 0, 1'b0);

        // Reset right after a transfer of 12 discards it and restarts at requester 0
        setDigit(0, 64'd12);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("mid_ready", 64'(req_ready), 64'h1);
        cycle();
        rst = 1'b1;
        applyStimulus(4'h0, 1'b1);
        cycle();
        checkRsp("mid_rst", 1'b0, 0, 1'b0);
        rst = 1'b0;
        cycle();
        checkRsp("mid_after", 1'b0, 0, 1'b0);
        applyStimulus(4'hF, 1'b1);
        checkOutput("mid_ptr0", 64'(req_ready), 64'h1);
        applyStimulus(4'h0, 1'b1);

        // All-ones and 2^63 operands
        setDigit(1, '1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("bnd_ready", 64'(req_ready), 64'h2);
        cycle();
        setDigit(1, 64'h8000_0000_0000_0000);
        cycle();
        checkRsp("bnd_ones", 1'b1, 1, 1'b1);
        applyStimulus(4'h0, 1'b1);
        cycle();
        checkRsp("bnd_msb", 1'b1, 1, 1'b0);
        cycle();
        checkRsp("bnd_idle", 1'b0, 0, 1'b0);

        // Random sweep against an in-order scoreboard, then drain
        for (int i = 0; i < NREQ; i++) setDigit(i, randDigit());
        applyStimulus(4'(($urandom) & 32'hF), 1'b1);
        for (int cyc = 0; cyc < 10006; cyc++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (qId.size() == 0) begin
                    checkOutput("sb_extra_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    ei = qId.pop_front();
                    ed = qDiv.pop_front();
                    checkOutput("sb_id", 64'(rsp_id), 64'(ei));
                    checkOutput("sb_div", 64'(rsp_div), 64'(ed));
                end
            end
            checkOutput("sb_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            checkOutput("sb_ready_valid", 64'(req_ready & ~req_valid), 64'd0);
            xferMask = req_valid & req_ready;
            if (xferMask != 4'h0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (xferMask[i]) begin
                        d = req_digit[i*SIZE +: SIZE];
                        qId.push_back(i);
                        qDiv.push_back((d % 64'd3) == 64'd0);
                        checkOutput("sb_wait", 64'(waitCnt[i] <= NREQ - 1), 64'd1);
                        waitCnt[i] = 0;
                    end else if (req_valid[i]) begin
                        waitCnt[i]++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (cyc < 10000) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] || xferMask[i]) begin
                        req_valid[i] = ($urandom_range(1, 0) == 1);
                        setDigit(i, randDigit());
                    end
                end
                rsp_ready = ($urandom_range(3, 0) != 0);
            end else begin
                req_valid = '0;
                rsp_ready = 1'b1;
            end
        end
        checkOutput("sb_drained", 64'(qId.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
